// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB master and its timeout counter.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles; expired_o flags the cycle that is the TIMEOUT-th wait cycle.
module apb_timeout_counter import apb_pkg::*; #(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_q;

  assign expired_o = (count_q == LIMIT);

  // Wait-cycle count, saturating at the limit so expired_o stays asserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else if (clear_i) begin
      count_q <= 8'd0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + 8'd1;
    end else begin
      count_q <= count_q;
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, SETUP/ACCESS transfer, held response out.
module apb_master import apb_pkg::*; #(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  apb_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              accept_s, expired_s;

  // cmd_ready_q is only ever set while the FSM sits in IDLE.
  assign accept_s = cmd_valid_i & cmd_ready_q;

  apb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i     (pclk_i),
    .rst_i     (preset_i),
    .clear_i   (state_q != ACCESS),
    .enable_i  (state_q == ACCESS),
    .expired_o (expired_s)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = 1'b0;
    psel_d        = 1'b0;
    penable_d     = 1'b0;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write_i;
          paddr_d  = cmd_addr_i;
          pwdata_d = cmd_write_i ? cmd_wdata_i : {DATA_W{1'b0}};
        end else begin
          cmd_ready_d = 1'b1;
          pwrite_d    = 1'b0;
          paddr_d     = {ADDR_W{1'b0}};
          pwdata_d    = {DATA_W{1'b0}};
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready_i || expired_s) begin
          // pready_i wins over a timeout landing in the same cycle.
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (pready_i && !pwrite_q) ? prdata_i : {DATA_W{1'b0}};
          rsp_err_d     = pready_i ? pslverr_i : 1'b1;
          rsp_timeout_d = !pready_i;
          pwrite_d      = 1'b0;
          paddr_d       = {ADDR_W{1'b0}};
          pwdata_d      = {DATA_W{1'b0}};
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d       = IDLE;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = {DATA_W{1'b0}};
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d       = IDLE;
        pwrite_d      = 1'b0;
        paddr_d       = {ADDR_W{1'b0}};
        pwdata_d      = {DATA_W{1'b0}};
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = {DATA_W{1'b0}};
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops every output at once.
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= {ADDR_W{1'b0}};
      pwdata_q      <= {DATA_W{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DATA_W{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule
